// File: rtl/hazard_pkg.sv
// Shared definitions for the ID/EX hazard and stall controller.
// FSM state encoding, default register-field width and control-bundle constants.
package hazard_pkg;

  localparam int DEF_REG_AW = 3;
  localparam int REM_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic hazard;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE   = '{hazard: 1'b0, pc_write: 1'b1, ifid_write: 1'b1,
                                       ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam hz_ctrl_t CTRL_STALL  = '{hazard: 1'b1, pc_write: 1'b0, ifid_write: 1'b0,
                                       ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH = '{hazard: 1'b0, pc_write: 1'b1, ifid_write: 1'b1,
                                       ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_FREEZE = '{hazard: 1'b0, pc_write: 1'b0, ifid_write: 1'b0,
                                       ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Combinational load-use comparator: a load in EX writes a register the ID
// instruction actually reads. Register 0 is compared like any other.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              EX_memread,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_uses_rs,
  input  logic              ID_uses_rt,
  output logic              luse
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = ID_uses_rs && (EX_rt == ID_rs);
    rt_hit = ID_uses_rt && (EX_rt == ID_rt);
    luse   = EX_memread && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard controller: multi-cycle load-use stall, taken-branch flush and
// memory-busy freeze. Optional saturating stall counter under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EX_memread,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_uses_rs,
  input  logic              ID_uses_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              hazard,
  output logic              PCWrite,
  output logic              IF_IDwrite,
  output logic              IF_IDflush,
  output logic              ID_EXflush,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);

  hz_state_t        state, state_n;
  logic [REM_W-1:0] rem, rem_n;
  logic             luse;
  hz_ctrl_t         ctrl;

  hazard_match #(
    .REG_AW (REG_AW)
  ) u_match (
    .EX_memread (EX_memread),
    .EX_rt      (EX_rt),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_uses_rs (ID_uses_rs),
    .ID_uses_rt (ID_uses_rt),
    .luse       (luse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    if (!mem_busy) begin
      unique case (state)
        IDLE: begin
          if (branch_taken) begin
            state_n = FLUSH;
            rem_n   = '0;
          end else if (luse && (LOAD_LAT > 1)) begin
            state_n = STALL;
            rem_n   = REM_INIT;
          end
        end
        STALL: begin
          if (branch_taken) begin
            state_n = FLUSH;
            rem_n   = '0;
          end else if (rem == REM_W'(1)) begin
            state_n = IDLE;
            rem_n   = '0;
          end else begin
            rem_n = rem - REM_W'(1);
          end
        end
        FLUSH: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          rem_n   = '0;
        end
      endcase
    end
  end

  // Reset is gated in here as well: in IDLE a live luse would otherwise leak
  // through to the outputs while reset is still held.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!reset) begin
      ctrl = CTRL_IDLE;
    end else if (mem_busy) begin
      ctrl = CTRL_FREEZE;
    end else begin
      unique case (state)
        IDLE: begin
          if (branch_taken)  ctrl = CTRL_BRANCH;
          else if (luse)     ctrl = CTRL_STALL;
        end
        STALL: begin
          if (branch_taken)  ctrl = CTRL_BRANCH;
          else               ctrl = CTRL_STALL;
        end
        FLUSH:   ctrl = CTRL_IDLE;
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  always_comb begin
    hazard     = ctrl.hazard;
    PCWrite    = ctrl.pc_write;
    IF_IDwrite = ctrl.ifid_write;
    IF_IDflush = ctrl.ifid_flush;
    ID_EXflush = ctrl.idex_flush;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (LOAD_LAT=3) with a hazard-cycles-owed
// reference model; works with or without HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

  localparam int AW  = 3;
  localparam int LAT = 3;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          EX_memread, ID_uses_rs, ID_uses_rt, branch_taken, mem_busy;
  logic [AW-1:0] EX_rt, ID_rs, ID_rt;
  logic          hazard, PCWrite, IF_IDwrite, IF_IDflush, ID_EXflush;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // bundle order {hazard, PCWrite, IF_IDwrite, IF_IDflush, ID_EXflush}
  localparam logic [4:0] O_IDLE   = 5'b01100;
  localparam logic [4:0] O_STALL  = 5'b10001;
  localparam logic [4:0] O_BRANCH = 5'b01111;
  localparam logic [4:0] O_FREEZE = 5'b00000;

  hazard_stall_ctrl #(
    .REG_AW   (AW),
    .LOAD_LAT (LAT),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .EX_memread   (EX_memread),
    .EX_rt        (EX_rt),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_uses_rs   (ID_uses_rs),
    .ID_uses_rt   (ID_uses_rt),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .hazard       (hazard),
    .PCWrite      (PCWrite),
    .IF_IDwrite   (IF_IDwrite),
    .IF_IDflush   (IF_IDflush),
    .ID_EXflush   (ID_EXflush),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // Model: how many hazard cycles a started load-use still owes, whether the
  // next cycle is the post-branch bubble, and the hazard-cycle tally.
  int          owed;
  logic        flush_pend;
  logic [CW-1:0] m_cnt;

  function automatic logic m_luse();
    return EX_memread && ((ID_uses_rs && EX_rt == ID_rs) || (ID_uses_rt && EX_rt == ID_rt));
  endfunction

  function automatic logic [4:0] m_out();
    if (!rst_n)                   return O_IDLE;
    if (mem_busy)                 return O_FREEZE;
    if (flush_pend)               return O_IDLE;
    if (branch_taken)             return O_BRANCH;
    if (owed > 0 || m_luse())     return O_STALL;
    return O_IDLE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owed       <= 0;
      flush_pend <= 1'b0;
      m_cnt      <= '0;
    end else if (!mem_busy) begin
      if (flush_pend) begin
        flush_pend <= 1'b0;
      end else if (branch_taken) begin
        owed       <= 0;
        flush_pend <= 1'b1;
      end else if (owed > 0 || m_luse()) begin
        owed <= ((owed == 0) ? LAT : owed) - 1;
        if (m_cnt != '1) m_cnt <= m_cnt + 1'b1;
      end
    end
  end

  function automatic logic [4:0] dut_out();
    return {hazard, PCWrite, IF_IDwrite, IF_IDflush, ID_EXflush};
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input logic [CW-1:0] c);
`ifdef HAZARD_PERF_CNT_EN
    return c;
`else
    return c & '0;
`endif
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    chk("model_outputs", CW'(dut_out()), CW'(m_out()));
    chk("model_stall_count", stall_count, exp_cnt(m_cnt));
  endtask

  task automatic sample();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int hz;

  initial begin
    rst_n = 1'b0; EX_memread = 1'b1; EX_rt = 3'b010; ID_rs = 3'b010; ID_rt = 3'b000;
    ID_uses_rs = 1'b1; ID_uses_rt = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;

    // reset with a live match must still give idle outputs
    sample();
    chk("reset_outputs", CW'(dut_out()), CW'(O_IDLE));
    chk("reset_count", stall_count, '0);
    EX_memread = 1'b0;
    adv();
    rst_n = 1'b1;

    // no hazard: no load
    EX_rt = 3'd1; ID_rs = 3'd3; ID_rt = 3'd2; ID_uses_rs = 1'b1; ID_uses_rt = 1'b1;
    sample();
    chk("no_load_idle", CW'(dut_out()), CW'(O_IDLE));
    adv();
    // load matches rt but rt not used
    EX_memread = 1'b1; EX_rt = 3'd2; ID_uses_rt = 1'b0;
    sample();
    chk("unused_rt_idle", CW'(dut_out()), CW'(O_IDLE));
    adv();

    // uninterrupted load-use: exactly 3 hazard cycles
    EX_rt = 3'b010; ID_rt = 3'b010; ID_uses_rt = 1'b1;
    hz = 0;
    sample();
    chk("luse_first_cycle", CW'(dut_out()), CW'(O_STALL));
    if (hazard) hz++;
    adv();
    EX_memread = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (hazard) hz++;
      adv();
    end
    chk("luse_hazard_cycles", CW'(hz), CW'(LAT));
    chk("luse_count", stall_count, exp_cnt(CW'(3)));

    // branch on the second stall cycle
    EX_memread = 1'b1;
    sample();
    chk("br_stall_start", CW'(dut_out()), CW'(O_STALL));
    adv();
    EX_memread = 1'b0; branch_taken = 1'b1;
    sample();
    chk("br_flush_cycle", CW'(dut_out()), CW'(O_BRANCH));
    adv();
    branch_taken = 1'b0;
    sample();
    chk("br_flush_state_idle", CW'(dut_out()), CW'(O_IDLE));
    adv();
    sample();
    chk("br_back_idle", CW'(dut_out()), CW'(O_IDLE));
    adv();
    chk("br_count", stall_count, exp_cnt(CW'(4)));

    // freeze two cycles while two stall cycles remain
    hz = 0;
    EX_memread = 1'b1;
    sample();
    if (hazard) hz++;
    adv();
    EX_memread = 1'b0; mem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("freeze_outputs", CW'(dut_out()), CW'(O_FREEZE));
      if (hazard) hz++;
      adv();
    end
    mem_busy = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (hazard) hz++;
      adv();
    end
    chk("freeze_hazard_cycles", CW'(hz), CW'(LAT));
    chk("freeze_count", stall_count, exp_cnt(CW'(7)));

    // asynchronous reset in the middle of a stall
    EX_memread = 1'b1;
    sample();
    adv();
    EX_memread = 1'b0;
    sample();
    chk("areset_pre_stall", CW'(dut_out()), CW'(O_STALL));
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_immediate", CW'(dut_out()), CW'(O_IDLE));
    chk("areset_count", stall_count, '0);
    model_cmp();
    adv();
    rst_n = 1'b1;
    sample();
    chk("areset_release_idle", CW'(dut_out()), CW'(O_IDLE));
    adv();
    sample();
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
